// File: rtl/rs_codeword_assembler_if.sv
// Beat-in / codeword-out bundle between the DQ capture path and the RS erasure decoder.
interface rs_codeword_assembler_if #(
  parameter int CHIPS      = 10,
  parameter int CHIP_W     = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int SYM_W = 8;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                      beat_valid;
  logic [CHIPS*CHIP_W-1:0]   beat_data;
  logic [CHIPS-1:0]          beat_chip_err;
  logic                      erase_wr_en;
  logic [CHIPS-1:0]          erase_wr_mask;
  logic                      cw_valid;
  logic                      cw_ready;
  logic [CHIPS*SYM_W-1:0]    codeword_out;
  logic [CHIPS-1:0]          due_info_out;
  logic                      overflow;
  logic [15:0]               drop_count;
  logic [LVL_W-1:0]          fifo_level;

  modport master (
    output beat_valid, beat_data, beat_chip_err, erase_wr_en, erase_wr_mask, cw_ready,
    input  cw_valid, codeword_out, due_info_out, overflow, drop_count, fifo_level
  );

  modport slave (
    input  beat_valid, beat_data, beat_chip_err, erase_wr_en, erase_wr_mask, cw_ready,
    output cw_valid, codeword_out, due_info_out, overflow, drop_count, fifo_level
  );
endinterface

// File: rtl/rs_codeword_assembler.sv
// Packs DQ beats into 80-bit RS codewords with per-chip erasure flags and queues them
// for the erasure decoder.

// One chip's symbol accumulator and dynamic error flag.
module rs_cw_lane #(
  parameter int CHIP_W = 4,
  parameter int BEATS  = 2,
  parameter int BW     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_valid,
  input  logic              beat_last,
  input  logic [BW-1:0]     beat_idx,
  input  logic [CHIP_W-1:0] nib,
  input  logic              chip_err,
  input  logic              static_bad,
  output logic [CHIP_W*BEATS-1:0] sym,
  output logic              erased
);
  localparam int SYM_W = CHIP_W * BEATS;

  logic [SYM_W-1:0] sym_q;
  logic             err_q;

  // sym is the symbol including the current beat, so the completion cycle needs no extra stage
  always_comb begin
    sym = sym_q;
    for (int b = 0; b < BEATS; b++)
      if (beat_idx == BW'(b)) sym[SYM_W-1-CHIP_W*b -: CHIP_W] = nib;
  end

  assign erased = err_q | chip_err | static_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q <= '0;
      err_q <= 1'b0;
    end else if (beat_valid) begin
      if (beat_last) begin
        sym_q <= '0;
        err_q <= 1'b0;
      end else begin
        sym_q <= sym;
        err_q <= err_q | chip_err;
      end
    end
  end
endmodule

module rs_codeword_assembler #(
  parameter int CHIPS      = 10,
  parameter int CHIP_W     = 4,
  parameter int BEATS      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rs_codeword_assembler_if.slave bus
);
  localparam int SYM_W = CHIP_W * BEATS;
  localparam int CW_W  = CHIPS * SYM_W;
  localparam int ENT_W = CW_W + CHIPS;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  logic [BW-1:0]                  beat_cnt;
  logic                           beat_last;
  logic                           complete;
  logic [CHIPS-1:0]               static_mask;
  logic [CHIPS-1:0][CHIP_W-1:0]   beat_lanes;
  logic [CHIPS-1:0][SYM_W-1:0]    syms;
  logic [CHIPS-1:0]               erased;

  logic [FIFO_DEPTH-1:0][ENT_W-1:0] mem;
  logic [PW-1:0]                  wr_ptr, rd_ptr;
  logic [LW-1:0]                  level;
  logic                           push, pop, full;

  // Packed index j is chip CHIPS-1-j, which matches the MSB-first chip order on every bus
  assign beat_lanes = bus.beat_data;
  assign beat_last  = (beat_cnt == BW'(BEATS-1));
  assign complete   = bus.beat_valid && beat_last;

  for (genvar j = 0; j < CHIPS; j++) begin : g_lane
    rs_cw_lane #(.CHIP_W(CHIP_W), .BEATS(BEATS), .BW(BW)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .beat_valid (bus.beat_valid),
      .beat_last  (beat_last),
      .beat_idx   (beat_cnt),
      .nib        (beat_lanes[j]),
      .chip_err   (bus.beat_chip_err[j]),
      .static_bad (static_mask[j]),
      .sym        (syms[j]),
      .erased     (erased[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt    <= '0;
      static_mask <= '0;
    end else begin
      if (bus.beat_valid) beat_cnt <= beat_last ? '0 : beat_cnt + BW'(1);
      if (bus.erase_wr_en) static_mask <= bus.erase_wr_mask;
    end
  end

  assign full = (level == LW'(FIFO_DEPTH));
  assign pop  = bus.cw_valid && bus.cw_ready;
  // A full FIFO still accepts the burst when the head leaves in the same cycle
  assign push = complete && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {syms, erased};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      bus.overflow   <= 1'b0;
      bus.drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      if (complete && !push) begin
        bus.overflow <= 1'b1;
        if (bus.drop_count != 16'hFFFF) bus.drop_count <= bus.drop_count + 16'd1;
      end
    end
  end

  assign bus.cw_valid   = (level != '0);
  assign bus.fifo_level = level;
  assign {bus.codeword_out, bus.due_info_out} = bus.cw_valid ? mem[rd_ptr] : '0;
endmodule
